// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline skid buffer and its counters.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam int unsigned STALL_CNTW = 16;

  // All-ones value of a w-bit counter; valid for w up to 64.
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  localparam logic [STALL_CNTW-1:0] STALL_SAT = STALL_CNTW'(sat_max(STALL_CNTW));

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter: counts inc_i cycles, sticks at all-ones, cleared only by rst.
module sat_cnt
  import pipe_pkg::*;
#(
  parameter int unsigned CNTW = STALL_CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_i,
  output logic [CNTW-1:0] cnt_o
);

  localparam logic [CNTW-1:0] SAT = CNTW'(sat_max(CNTW));

  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != SAT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_buf.sv
// Two-entry elastic pipeline register with flush and a saturating stall counter.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned CNTW   = STALL_CNTW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DWIDTH-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DWIDTH-1:0] out_data_o,
  output logic [1:0]        count_o,
  output logic [CNTW-1:0]   stall_cnt_o
);

  skid_state_e       state_q;
  logic [DWIDTH-1:0] main_q;
  logic [DWIDTH-1:0] skid_q;
  logic              acc_in;
  logic              acc_out;

  // Ready and valid come straight from state, so no out_ready_i -> in_ready_o path.
  assign in_ready_o  = (state_q != FULL);
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;
  assign acc_in      = in_valid_i & in_ready_o;
  assign acc_out     = out_valid_o & out_ready_i;

  always_comb begin
    count_o = 2'd0;
    unique case (state_q)
      EMPTY:   count_o = 2'd0;
      BUSY:    count_o = 2'd1;
      FULL:    count_o = 2'd2;
      default: count_o = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      // Data registers are left as-is; they are don't-care once EMPTY.
      state_q <= EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc_in) begin
            state_q <= BUSY;
            main_q  <= in_data_i;
          end
        end
        BUSY: begin
          if (acc_in && acc_out) begin
            main_q <= in_data_i;
          end else if (acc_in) begin
            state_q <= FULL;
            skid_q  <= in_data_i;
          end else if (acc_out) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (acc_out) begin
            state_q <= BUSY;
            main_q  <= skid_q;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  sat_cnt #(
    .CNTW(CNTW)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (out_valid_o & ~out_ready_i),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Self-checking bench for pipe_skid_buf against a queue-based reference model.
module tb_pipe_skid_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic [31:0] in_data_i;
  logic        out_ready_i;

  logic        in_ready_o, out_valid_o;
  logic [31:0] out_data_o;
  logic [1:0]  count_o;
  logic [15:0] stall_cnt_o;

  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [1:0]  b_count;
  logic [1:0]  b_stall;

  int nchk = 0;
  int nfail = 0;

  // Reference model: queue of held entries, oldest first, plus stall counts.
  logic [31:0] mq[$];
  int          ms16;
  int          ms2;

  always #5 clk = ~clk;

  pipe_skid_buf #(.DWIDTH(32), .CNTW(16)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .count_o(count_o), .stall_cnt_o(stall_cnt_o)
  );

  pipe_skid_buf #(.DWIDTH(32), .CNTW(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(b_in_ready), .in_data_i(in_data_i),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready_i), .out_data_o(b_out_data),
    .count_o(b_count), .stall_cnt_o(b_stall)
  );

  // Data held under backpressure must not move across an edge.
  logic        hold_prev = 1'b0;
  logic [31:0] data_prev;
  always @(posedge clk) begin
    hold_prev <= out_valid_o & ~out_ready_i & ~rst;
    data_prev <= out_data_o;
  end
  always @(negedge clk) begin
    if (hold_prev) begin
      nchk++;
      if (out_data_o !== data_prev) begin
        nfail++;
        $display("FAIL stable_data: got %h required %h", out_data_o, data_prev);
      end
    end
  end

  task automatic step(input logic f, input logic v, input logic [31:0] d, input logic r);
    bit mv, mr;
    flush_i = f; in_valid_i = v; in_data_i = d; out_ready_i = r;
    @(posedge clk);
    if (rst) begin
      mq.delete(); ms16 = 0; ms2 = 0;
    end else begin
      mv = (mq.size() != 0);
      mr = (mq.size() < 2);
      if (mv && !r) begin
        if (ms16 < 65535) ms16++;
        if (ms2 < 3) ms2++;
      end
      if (mv && r) void'(mq.pop_front());
      if (f) mq.delete();
      else if (v && mr) mq.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(0, 1, 32'hDEAD, 0);
    step(0, 1, 32'hBEEF, 1);
    rst = 1'b0;
    nchk++; if (out_valid_o !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %b required 0", out_valid_o); end
    nchk++; if (in_ready_o !== 1'b1) begin nfail++; $display("FAIL reset_ready: got %b required 1", in_ready_o); end
    nchk++; if (count_o !== 2'd0) begin nfail++; $display("FAIL reset_count: got %0d required 0", count_o); end
    nchk++; if (stall_cnt_o !== 16'd0) begin nfail++; $display("FAIL reset_stall: got %0d required 0", stall_cnt_o); end
    nchk++; if (out_data_o !== 32'd0) begin nfail++; $display("FAIL reset_data: got %h required 0", out_data_o); end
  endtask

  task automatic test_streaming();
    logic [31:0] vals[3] = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) begin
      step(0, 1, vals[i], 1);
      nchk++; if (out_data_o !== vals[i] || out_valid_o !== 1'b1) begin
        nfail++; $display("FAIL stream_data[%0d]: got %h/%b required %h/1", i, out_data_o, out_valid_o, vals[i]);
      end
      nchk++; if (count_o !== 2'd1) begin nfail++; $display("FAIL stream_count[%0d]: got %0d required 1", i, count_o); end
    end
    step(0, 0, 32'h0, 1);
    nchk++; if (count_o !== 2'd0) begin nfail++; $display("FAIL stream_drain: got %0d required 0", count_o); end
  endtask

  task automatic test_backpressure();
    step(0, 1, 32'hA, 0);
    step(0, 1, 32'hB, 0);
    nchk++; if (count_o !== 2'd2) begin nfail++; $display("FAIL bp_count: got %0d required 2", count_o); end
    nchk++; if (in_ready_o !== 1'b0) begin nfail++; $display("FAIL bp_ready: got %b required 0", in_ready_o); end
    nchk++; if (out_data_o !== 32'hA) begin nfail++; $display("FAIL bp_head: got %h required a", out_data_o); end
    step(0, 1, 32'hF00, 0);
    nchk++; if (out_data_o !== 32'hA || count_o !== 2'd2) begin
      nfail++; $display("FAIL bp_hold: got %h/%0d required a/2", out_data_o, count_o);
    end
    step(0, 0, 32'h0, 1);
    nchk++; if (out_data_o !== 32'hB || in_ready_o !== 1'b1 || count_o !== 2'd1) begin
      nfail++; $display("FAIL bp_pop1: got %h/%b/%0d required b/1/1", out_data_o, in_ready_o, count_o);
    end
    step(0, 0, 32'h0, 1);
    nchk++; if (out_valid_o !== 1'b0) begin nfail++; $display("FAIL bp_pop2: got %b required 0", out_valid_o); end
  endtask

  task automatic test_flush();
    step(0, 1, 32'hD, 0);
    step(0, 1, 32'hE, 0);
    step(1, 1, 32'hC, 0);
    nchk++; if (count_o !== 2'd0 || out_valid_o !== 1'b0) begin
      nfail++; $display("FAIL flush_full: got %0d/%b required 0/0", count_o, out_valid_o);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 32'h0, 1);
      nchk++; if (out_valid_o !== 1'b0) begin nfail++; $display("FAIL flush_ghost[%0d]: got valid %b data %h required 0", i, out_valid_o, out_data_o); end
    end
    step(0, 1, 32'h5, 0);
    step(1, 1, 32'hC, 1);
    nchk++; if (count_o !== 2'd0 || out_valid_o !== 1'b0) begin
      nfail++; $display("FAIL flush_busy: got %0d/%b required 0/0", count_o, out_valid_o);
    end
  endtask

  task automatic test_stall_sat();
    logic [1:0] exp2[6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    rst = 1'b1; step(0, 0, 32'h0, 0); rst = 1'b0;
    step(0, 1, 32'h77, 0);
    nchk++; if (b_stall !== 2'd0) begin nfail++; $display("FAIL stall_start: got %0d required 0", b_stall); end
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 32'h0, 0);
      nchk++; if (b_stall !== exp2[i]) begin nfail++; $display("FAIL stall_sat[%0d]: got %0d required %0d", i, b_stall, exp2[i]); end
      nchk++; if (stall_cnt_o !== 16'(i + 1)) begin nfail++; $display("FAIL stall_wide[%0d]: got %0d required %0d", i, stall_cnt_o, i + 1); end
    end
    step(1, 0, 32'h0, 0);
    nchk++; if (b_stall !== 2'd3) begin nfail++; $display("FAIL stall_flush: got %0d required 3", b_stall); end
    rst = 1'b1; step(0, 0, 32'h0, 0); rst = 1'b0;
    nchk++; if (b_stall !== 2'd0 || stall_cnt_o !== 16'd0) begin
      nfail++; $display("FAIL stall_rst: got %0d/%0d required 0/0", b_stall, stall_cnt_o);
    end
  endtask

  task automatic test_random();
    logic f, v, r;
    logic [31:0] d;
    for (int i = 0; i < 10000; i++) begin
      nchk++; if (out_valid_o !== (mq.size() != 0) || in_ready_o !== (mq.size() < 2) ||
                  count_o !== 2'(mq.size())) begin
        nfail++; $display("FAIL rand_ctrl[%0d]: got v%b r%b c%0d required size %0d", i, out_valid_o, in_ready_o, count_o, mq.size());
      end
      if (mq.size() != 0) begin
        nchk++; if (out_data_o !== mq[0]) begin
          nfail++; $display("FAIL rand_data[%0d]: got %h required %h", i, out_data_o, mq[0]);
        end
      end
      nchk++; if (stall_cnt_o !== 16'(ms16) || b_stall !== 2'(ms2)) begin
        nfail++; $display("FAIL rand_stall[%0d]: got %0d/%0d required %0d/%0d", i, stall_cnt_o, b_stall, ms16, ms2);
      end
      f = ($urandom_range(0, 63) == 0);
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      d = $urandom;
      step(f, v, d, r);
    end
  endtask

  initial begin
    rst = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    ms16 = 0; ms2 = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_stall_sat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
